// File: rtl/pipe_stage_if.sv
// Handshake/payload bundle between a pipeline stage register and its neighbours.
// The master drives the stage inputs and control; the slave is the stage itself.
interface pipe_stage_if #(
  parameter int N_CH  = 2,
  parameter int REG_W = 5,
  parameter int EXC_W = 5,
  parameter int CNT_W = 16
);
  logic                       Req;
  logic                       flush;
  logic                       stall;
  logic [31:0]                Instr_In;
  logic [31:0]                PC_In;
  logic [REG_W-1:0]           WriteReg_In;
  logic [N_CH-1:0][31:0]      Data_In;
  logic [EXC_W-1:0]           ExcCode_In;
  logic                       isdelay_In;

  logic [31:0]                Instr_Out;
  logic [31:0]                PC_Out;
  logic [REG_W-1:0]           WriteReg_Out;
  logic [N_CH-1:0][31:0]      Data_Out;
  logic [EXC_W-1:0]           ExcCode_Out;
  logic                       isdelay_Out;
  logic                       valid_Out;
  logic [CNT_W-1:0]           stall_cnt;
  logic [CNT_W-1:0]           flush_cnt;

  modport master (
    output Req, flush, stall, Instr_In, PC_In, WriteReg_In, Data_In, ExcCode_In, isdelay_In,
    input  Instr_Out, PC_Out, WriteReg_Out, Data_Out, ExcCode_Out, isdelay_Out, valid_Out,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  Req, flush, stall, Instr_In, PC_In, WriteReg_In, Data_In, ExcCode_In, isdelay_In,
    output Instr_Out, PC_Out, WriteReg_Out, Data_Out, ExcCode_Out, isdelay_Out, valid_Out,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with exception redirect, bubble insertion, stall hold
// and saturating stall/flush event counters. Priority: reset > Req > flush > stall > load.

// One 32-bit data channel: cleared on reset or bubble, frozen on stall.
module pipe_stage_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        hold,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] r = '0;

  always_ff @(posedge clk) begin
    if (reset || clr) r <= '0;
    else if (!hold)   r <= d;
  end

  assign q = r;
endmodule

module pipe_stage_reg #(
  parameter int          N_CH      = 2,
  parameter int          REG_W     = 5,
  parameter int          EXC_W     = 5,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int          CNT_W     = 16
) (
  input logic          clk,
  input logic          reset,
  pipe_stage_if.slave  bus
);
  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [REG_W-1:0] wr;
    logic [EXC_W-1:0] exc;
    logic             isd;
    logic             vld;
  } ctl_t;

  ctl_t             st        = '0;
  logic [CNT_W-1:0] stall_cnt = '0;
  logic [CNT_W-1:0] flush_cnt = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.Req) begin
      st    <= '0;
      st.pc <= EXC_ENTRY;
      if (~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end else if (bus.flush) begin
      // Bubble keeps the PC and delay-slot flag so a later exception reports the right EPC.
      st     <= '0;
      st.pc  <= bus.PC_In;
      st.isd <= bus.isdelay_In;
      if (~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end else if (bus.stall) begin
      if (~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end else begin
      st.instr <= bus.Instr_In;
      st.pc    <= bus.PC_In;
      st.wr    <= bus.WriteReg_In;
      st.exc   <= bus.ExcCode_In;
      st.isd   <= bus.isdelay_In;
      st.vld   <= 1'b1;
    end
  end

  // Data channels share the same clear/hold decode as the control fields.
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    pipe_stage_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.Req | bus.flush),
      .hold  (bus.stall),
      .d     (bus.Data_In[k]),
      .q     (bus.Data_Out[k])
    );
  end

  assign bus.Instr_Out    = st.instr;
  assign bus.PC_Out       = st.pc;
  assign bus.WriteReg_Out = st.wr;
  assign bus.ExcCode_Out  = st.exc;
  assign bus.isdelay_Out  = st.isd;
  assign bus.valid_Out    = st.vld;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a default-width stage and a CNT_W=2 stage run the same
// directed vectors; expected post-edge state is queued and checked by a monitor.
module tb_pipe_stage_reg;
  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [4:0]       wr;
    logic [1:0][31:0] data;
    logic [4:0]       exc;
    logic             isd;
    logic             vld;
    logic [15:0]      sc;
    logic [15:0]      fc;
    logic [1:0]       sc2;
    logic [1:0]       fc2;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t mdl   = '0;
  exp_t sb[$];
  exp_t e, got;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  pipe_stage_if #(.N_CH(2), .REG_W(5), .EXC_W(5), .CNT_W(16)) bus1 ();
  pipe_stage_if #(.N_CH(2), .REG_W(5), .EXC_W(5), .CNT_W(2))  bus2 ();

  pipe_stage_reg #(.N_CH(2), .REG_W(5), .EXC_W(5), .EXC_ENTRY(32'h0000_4180), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  pipe_stage_reg #(.N_CH(2), .REG_W(5), .EXC_W(5), .EXC_ENTRY(32'h0000_4180), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  task automatic drive(input logic r, rq, fl, st, input logic [31:0] pc, instr,
                       input logic [4:0] wr, input logic [31:0] d0, d1,
                       input logic [4:0] exc, input logic isd);
    @(negedge clk);
    reset = r;
    bus1.Req = rq; bus1.flush = fl; bus1.stall = st;
    bus1.PC_In = pc; bus1.Instr_In = instr; bus1.WriteReg_In = wr;
    bus1.Data_In = {d1, d0}; bus1.ExcCode_In = exc; bus1.isdelay_In = isd;
    bus2.Req = rq; bus2.flush = fl; bus2.stall = st;
    bus2.PC_In = pc; bus2.Instr_In = instr; bus2.WriteReg_In = wr;
    bus2.Data_In = {d1, d0}; bus2.ExcCode_In = exc; bus2.isdelay_In = isd;
    if (r) begin
      mdl = '0;
    end else if (rq || fl) begin
      mdl.instr = '0; mdl.wr = '0; mdl.data = '0; mdl.exc = '0; mdl.vld = 1'b0;
      mdl.pc  = rq ? 32'h0000_4180 : pc;
      mdl.isd = rq ? 1'b0 : isd;
      if (mdl.fc != 16'hFFFF) mdl.fc = mdl.fc + 16'd1;
      if (mdl.fc2 != 2'd3)    mdl.fc2 = mdl.fc2 + 2'd1;
    end else if (st) begin
      if (mdl.sc != 16'hFFFF) mdl.sc = mdl.sc + 16'd1;
      if (mdl.sc2 != 2'd3)    mdl.sc2 = mdl.sc2 + 2'd1;
    end else begin
      mdl.instr = instr; mdl.pc = pc; mdl.wr = wr; mdl.data = {d1, d0};
      mdl.exc = exc; mdl.isd = isd; mdl.vld = 1'b1;
    end
    sb.push_back(mdl);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got.instr = bus1.Instr_Out;    got.pc  = bus1.PC_Out;
      got.wr    = bus1.WriteReg_Out; got.data = bus1.Data_Out;
      got.exc   = bus1.ExcCode_Out;  got.isd = bus1.isdelay_Out;
      got.vld   = bus1.valid_Out;    got.sc  = bus1.stall_cnt;
      got.fc    = bus1.flush_cnt;    got.sc2 = bus2.stall_cnt;
      got.fc2   = bus2.flush_cnt;
      checks++;
      if (got === e) passes++;
      else $display("FAIL stage_state t=%0t got=%h exp=%h", $time, got, e);
    end
  end

  initial begin
    bus1.Req = 0; bus1.flush = 0; bus1.stall = 0; bus1.PC_In = 0; bus1.Instr_In = 0;
    bus1.WriteReg_In = 0; bus1.Data_In = '0; bus1.ExcCode_In = 0; bus1.isdelay_In = 0;
    bus2.Req = 0; bus2.flush = 0; bus2.stall = 0; bus2.PC_In = 0; bus2.Instr_In = 0;
    bus2.WriteReg_In = 0; bus2.Data_In = '0; bus2.ExcCode_In = 0; bus2.isdelay_In = 0;
    #1;
    checks++;
    if ({bus1.Instr_Out, bus1.PC_Out, bus1.valid_Out, bus1.stall_cnt, bus1.flush_cnt, bus2.stall_cnt} === '0)
      passes++;
    else $display("FAIL powerup got pc=%h instr=%h vld=%b", bus1.PC_Out, bus1.Instr_Out, bus1.valid_Out);

    repeat (2) drive(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    drive(0, 0, 0, 0, 32'h3000, 32'h2408_0005, 5'd8, 32'd5, 32'd0, 5'd0, 1'b0);
    drive(0, 0, 0, 1, 32'h3004, 32'h1111_1111, 5'd3, 32'd7, 32'd9, 5'd2, 1'b1);
    drive(0, 0, 0, 1, 32'h3005, 32'h2222_2222, 5'd4, 32'd8, 32'd1, 5'd4, 1'b0);
    drive(0, 0, 0, 1, 32'h3006, 32'h3333_3333, 5'd5, 32'd6, 32'd2, 5'd1, 1'b1);
    drive(0, 0, 1, 0, 32'h3008, 32'h1234_5678, 5'd4, 32'd1, 32'd2, 5'd6, 1'b1);
    drive(0, 0, 0, 0, 32'h300C, 32'h8C09_0004, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd3, 1'b1);
    drive(0, 0, 1, 1, 32'h3010, 32'h0101_0101, 5'd7, 32'd3, 32'd4, 5'd1, 1'b0);
    drive(0, 0, 0, 0, 32'h3014, 32'hAC0A_0008, 5'd10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd0, 1'b0);
    drive(0, 1, 1, 1, 32'h3018, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1);
    drive(0, 0, 0, 0, 32'h301C, 32'h0000_1234, 5'd12, 32'd11, 32'd22, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(0, 0, 0, 1, 32'h4000 + 32'(i), 32'h5000 + 32'(i), 5'(i), 32'(i), 32'(i * 3), 5'(i), i[0]);
    drive(0, 1, 0, 0, 32'h3020, 32'h0000_5555, 5'd2, 32'd1, 32'd1, 5'd8, 1'b1);
    drive(0, 0, 1, 0, 32'h3024, 32'h0000_6666, 5'd3, 32'd2, 32'd2, 5'd0, 1'b0);
    drive(1, 1, 1, 1, 32'h3028, 32'h0000_7777, 5'd4, 32'd3, 32'd3, 5'd5, 1'b1);
    drive(0, 0, 0, 0, 32'h302C, 32'h0000_8888, 5'd6, 32'd4, 32'd5, 5'd0, 1'b1);
    drive(0, 0, 0, 0, 32'h302C, 32'h0000_8888, 5'd6, 32'd4, 32'd5, 5'd0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
